// File: rtl/clockworks_if.sv
// clockworks_if: the slow-domain clock and reset that the clock gearbox hands to the SoC.
//
// Signals:
//   clk     divided system clock (or the board clock when there is no division)
//   resetn  active-low system reset, stretched and aligned to the slow clock
//
// Modports:
//   master  the clock/reset generator that drives both signals
//   slave   a consumer in the slow domain
interface clockworks_if;
    logic clk;
    logic resetn;

    modport master (output clk, output resetn);
    modport slave  (input clk, input resetn);
endinterface

// File: rtl/clockworks.sv
// clockworks: clock gearbox and reset generator between the board clock/button and the SoC.
//
// The board clock CLK is divided by 2^(SLOW+1) to give a slow system clock. With SLOW=0,
// CLK is passed straight through. The active-low system reset is held low for HOLD slow
// periods after RESET is released and only changes on a slow-clock falling edge, so the
// slow domain sees HOLD clean rising edges under reset with half a period of setup margin.
//
// Parameters:
//   SLOW  division exponent (0 = passthrough)
//   HOLD  slow periods resetn stays low after RESET is released (>= 1)
//
// Ports:
//   CLK    board clock; every register here runs on its rising edge
//   RESET  active-high reset, sampled synchronously on CLK
//   sys    master side of clockworks_if carrying clk and resetn
module clockworks #(
    parameter int unsigned SLOW = 0,
    parameter int unsigned HOLD = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    clockworks_if.master  sys
);

    localparam int unsigned HoldW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
    localparam logic [HoldW-1:0] HoldVal  = HoldW'(HOLD);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD - 1);

    // One CLK cycle per slow period: the one producing the clk falling edge.
    logic tick;

    generate
        if (SLOW > 0) begin : g_div
            // Power-up value matches the post-RESET state.
            logic [SLOW:0] div = '0;

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    div <= '0;
                end else begin
                    div <= div + (SLOW + 1)'(1);
                end
            end

            assign tick    = &div;
            assign sys.clk = div[SLOW];
        end else begin : g_pass
            assign tick    = 1'b1;
            assign sys.clk = CLK;
        end
    endgenerate

    logic [HoldW-1:0] hold_cnt = '0;
    logic             resetn_r = 1'b0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hold_cnt <= '0;
            resetn_r <= 1'b0;
        end else if (tick && (hold_cnt < HoldVal)) begin
            hold_cnt <= hold_cnt + HoldW'(1);
            // Release on the same edge the count reaches HOLD; saturate afterwards.
            if (hold_cnt == HoldLast) begin
                resetn_r <= 1'b1;
            end
        end
    end

    assign sys.resetn = resetn_r;

endmodule

// File: tb/tb_clockworks.sv
module tb_clockworks;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    always #5 CLK = ~CLK;

    clockworks_if if_a ();
    clockworks_if if_b ();
    clockworks_if if_c ();

    clockworks #(.SLOW(2), .HOLD(4)) u_a (.CLK(CLK), .RESET(RESET), .sys(if_a));
    clockworks #(.SLOW(0), .HOLD(3)) u_b (.CLK(CLK), .RESET(RESET), .sys(if_b));
    clockworks #(.SLOW(3), .HOLD(1)) u_c (.CLK(CLK), .RESET(RESET), .sys(if_c));

    int n_checks = 0;
    int n_fail   = 0;
    // CLK edges with RESET low since the last RESET-high edge (or since power-up).
    int since_rel = 0;

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t since_rel=%0d: got %b expected %b",
                     tag, $time, since_rel, got, exp);
        end
    endtask

    // Slow clock is bit SLOW of the cycle count since release.
    function automatic logic exp_clk(input int n, input int slow);
        return ((n >> slow) & 1) != 0;
    endfunction

    // Reset is released after HOLD slow periods (HOLD CLK cycles when undivided).
    function automatic logic exp_rstn(input int n, input int slow, input int hold);
        int span;
        span = (slow > 0) ? hold * (1 << (slow + 1)) : hold;
        return n >= span;
    endfunction

    // Sampled while CLK is low.
    task automatic compare_all();
        check_bit("a_clk",    if_a.clk,    exp_clk(since_rel, 2));
        check_bit("a_resetn", if_a.resetn, exp_rstn(since_rel, 2, 4));
        check_bit("b_clk_lo", if_b.clk,    1'b0);
        check_bit("b_resetn", if_b.resetn, exp_rstn(since_rel, 0, 3));
        check_bit("c_clk",    if_c.clk,    exp_clk(since_rel, 3));
        check_bit("c_resetn", if_c.resetn, exp_rstn(since_rel, 3, 1));
    endtask

    // Drive RESET for one CLK cycle, advance the model, then check.
    task automatic step(input logic rst);
        RESET = rst;
        @(posedge CLK);
        if (RESET) since_rel = 0;
        else       since_rel++;
        #1;
        check_bit("b_clk_hi", if_b.clk, 1'b1);
        @(negedge CLK);
        compare_all();
    endtask

    task automatic run(input logic rst, input int cycles);
        for (int i = 0; i < cycles; i++) step(rst);
    endtask

    initial begin
        // Power-up without any RESET pulse.
        #1;
        compare_all();
        run(1'b0, 1000);

        // RESET for 3 cycles while running, then recover.
        run(1'b1, 3);
        run(1'b0, 40);

        // Second pulse mid-hold restarts the count.
        run(1'b1, 1);
        run(1'b0, 20);
        run(1'b1, 1);
        run(1'b0, 40);

        // Long RESET: everything held low.
        run(1'b1, 50);
        run(1'b0, 40);

        // Random pulses landing at arbitrary points of the slow period.
        for (int k = 0; k < 40; k++) begin
            run(1'b1, int'($urandom_range(1, 4)));
            run(1'b0, int'($urandom_range(0, 80)));
        end
        run(1'b0, 40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
